axi_rd_arbiter: RTL

Shares the single AXI read-address/read-data channel between the instruction cache and the data cache miss paths. Accepts one cache read request at a time, issues one AXI AR transaction (4-beat INCR line fill or single-beat uncached read) and routes the returned beats to the owning cache until `rlast`. It sits between the two cache refill ports and the AXI read channels. The existing write path is untouched.

---
 rtl/cpu_axi_pkg.sv | 21 ++
 rtl/arb2_grant.sv | 44 ++++
 rtl/axi_rd_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cpu_axi_pkg.sv
// Shared AXI read-side types and constants.
// Used by the cache refill read arbiter.
package cpu_axi_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } rd_state_e;

  localparam logic [3:0] ARID_INST      = 4'd0;
  localparam logic [3:0] ARID_DATA      = 4'd1;
  localparam logic [2:0] RD_TYPE_LINE   = 3'b100;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  function automatic logic [7:0] beat_inc(input logic [7:0] c);
    return (c == 8'hff) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/arb2_grant.sv
// Two-way grant generator: bit0 = inst, bit1 = data.
// ARB_RR_EN selects round-robin, otherwise data has fixed priority.
module arb2_grant (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

`ifdef ARB_RR_EN
  logic last_grant;

  // Favour whoever did not win last time
  always_comb begin
    gnt = 2'b00;
    if (req[1] && (!req[0] || !last_grant))
      gnt = 2'b10;
    else if (req[0])
      gnt = 2'b01;
  end

  // Remember the last winner; reset leaves data favoured
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      last_grant <= 1'b0;
    else if (adv && |req)
      last_grant <= gnt[1];
  end
`else
  logic unused_rr;
  assign unused_rr = &{1'b0, clk, resetn, adv};

  // Data always wins a tie
  always_comb begin
    gnt = 2'b00;
    if (req[1])
      gnt = 2'b10;
    else if (req[0])
      gnt = 2'b01;
  end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI AR/R channel between inst and data cache refills.
// Optional macro ARB_RR_EN: round-robin instead of data-first priority.
module axi_rd_arbiter
  import cpu_axi_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rd_req_inst,
  input  logic [2:0]        rd_type_inst,
  input  logic [ADDR_W-1:0] rd_addr_inst,
  output logic              rd_rdy_inst,
  output logic              ret_valid_inst,
  output logic              ret_last_inst,
  output logic [DATA_W-1:0] ret_data_inst,
  input  logic              rd_req_data,
  input  logic [2:0]        rd_type_data,
  input  logic [ADDR_W-1:0] rd_addr_data,
  output logic              rd_rdy_data,
  output logic              ret_valid_data,
  output logic              ret_last_data,
  output logic [DATA_W-1:0] ret_data_data,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic              rd_err
);

  localparam logic [7:0] LINE_LEN = 8'(BURST_LEN - 1);

  rd_state_e         state;
  logic              owner_data;
  logic [7:0]        beat_cnt;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              grant_now;
  logic              beat;
  logic              err_now;
  logic [2:0]        sel_type;
  logic [ADDR_W-1:0] sel_addr;

  assign req       = {rd_req_data, rd_req_inst};
  assign grant_now = (state == S_IDLE) && (|req);

  arb2_grant u_grant (
    .clk    (clk),
    .resetn (resetn),
    .req    (req),
    .adv    (grant_now),
    .gnt    (gnt)
  );

  assign rd_rdy_inst = grant_now & gnt[0];
  assign rd_rdy_data = grant_now & gnt[1];
  assign sel_type    = gnt[1] ? rd_type_data : rd_type_inst;
  assign sel_addr    = gnt[1] ? rd_addr_data : rd_addr_inst;

  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;

  assign beat           = rready & rvalid;
  assign ret_valid_inst = beat & ~owner_data;
  assign ret_last_inst  = beat & ~owner_data & rlast;
  assign ret_data_inst  = rdata;
  assign ret_valid_data = beat & owner_data;
  assign ret_last_data  = beat & owner_data & rlast;
  assign ret_data_data  = rdata;

  assign err_now = (rresp != 2'b00)
                 | (rid != arid)
                 | (rlast & (beat_cnt != arlen))
                 | (~rlast & (beat_cnt > arlen));

  // Request/address/data sequencing with registered AR and R handshakes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      owner_data <= 1'b0;
      beat_cnt   <= 8'd0;
      arid       <= '0;
      araddr     <= '0;
      arlen      <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (grant_now) begin
            owner_data <= gnt[1];
            araddr     <= sel_addr;
            arlen      <= (sel_type == RD_TYPE_LINE) ? LINE_LEN : 8'd0;
            arid       <= gnt[1] ? ARID_DATA : ARID_INST;
            arvalid    <= 1'b1;
            state      <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (arready) begin
            arvalid  <= 1'b0;
            rready   <= 1'b1;
            beat_cnt <= 8'd0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (rvalid) begin
            beat_cnt <= beat_inc(beat_cnt);
            if (err_now)
              rd_err <= 1'b1;
            if (rlast) begin
              rready <= 1'b0;
              state  <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
